// File: rtl/mul_div_pkg.sv
// ============================================================================
// mul_div_pkg : shared types and op-decoding helpers for the RV32M mul/div unit
// Revision    : 1.0
// ============================================================================
`default_nettype none

package mul_div_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } mdu_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } mdu_state_t;

    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic is_signed_a(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_signed_b(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_operand_prep.sv
// ============================================================================
// mdu_operand_prep : operand magnitude extraction and sign flags per op
// Revision         : 1.0
// ============================================================================
`default_nettype none

module mdu_operand_prep
    import mul_div_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] mag_a_o,
    output logic [XLEN-1:0] mag_b_o,
    output logic            neg_a_o,
    output logic            neg_b_o
);

    logic w_neg_a;
    logic w_neg_b;

    assign w_neg_a = is_signed_a(op_i) & a_i[XLEN-1];
    assign w_neg_b = is_signed_b(op_i) & b_i[XLEN-1];

    // The most-negative value negates to itself, which is its correct unsigned magnitude.
    assign mag_a_o = w_neg_a ? (~a_i + 1'b1) : a_i;
    assign mag_b_o = w_neg_b ? (~b_i + 1'b1) : b_i;
    assign neg_a_o = w_neg_a;
    assign neg_b_o = w_neg_b;

endmodule

`default_nettype wire

// File: rtl/mul_div_unit.sv
// ============================================================================
// mul_div_unit : iterative radix-2 RV32M multiply/divide, one bit per cycle
//                Divide datapath present only when MUL_DIV_UNIT_DIV_EN is defined.
// Revision     : 1.0
// ============================================================================
`default_nettype none

module mul_div_unit
    import mul_div_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            busy
);

    localparam int CNT_W = $clog2(XLEN + 1);

    mdu_state_t        state_q,   state_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    mdu_op_t           op_q,      op_d;
    logic [2*XLEN-1:0] acc_q,     acc_d;
    logic [XLEN-1:0]   opnd_q,    opnd_d;
    logic              neg_q,     neg_d;
    logic              special_q, special_d;
    logic [XLEN-1:0]   result_q,  result_d;

    logic [XLEN-1:0]   prep_mag_a;
    logic [XLEN-1:0]   prep_mag_b;
    logic              prep_neg_a;
    logic              prep_neg_b;

    mdu_operand_prep #(
        .XLEN (XLEN)
    ) u_prep (
        .op_i    (op),
        .a_i     (in_a),
        .b_i     (in_b),
        .mag_a_o (prep_mag_a),
        .mag_b_o (prep_mag_b),
        .neg_a_o (prep_neg_a),
        .neg_b_o (prep_neg_b)
    );

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_step;
    logic [2*XLEN-1:0] mul_prod;
    logic [XLEN-1:0]   mul_res;

    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
    assign mul_step = {mul_sum, acc_q[XLEN-1:1]};
    assign mul_prod = neg_q ? (~acc_q + 1'b1) : acc_q;
    assign mul_res  = (op_q == OP_MUL) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];

`ifdef MUL_DIV_UNIT_DIV_EN
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    // Divide: acc = {partial remainder, dividend bits shifting out / quotient bits shifting in}.
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] div_step;
    logic [XLEN-1:0]   div_sel;
    logic [XLEN-1:0]   div_res;
    logic              div_ovf;

    assign div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, opnd_q};
    assign div_step  = div_diff[XLEN]
                     ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                     : {div_diff[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};
    assign div_sel   = op_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
    assign div_res   = neg_q ? (~div_sel + 1'b1) : div_sel;
    assign div_ovf   = is_signed_a(op) && (in_a == INT_MIN) && (in_b == {XLEN{1'b1}});
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        neg_d     = neg_q;
        special_d = special_q;
        result_d  = result_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d      = mdu_op_t'(op);
                    cnt_d     = CNT_W'(XLEN);
                    special_d = 1'b0;
                    state_d   = S_BUSY;
                    if (is_div(op)) begin
                        acc_d  = {{XLEN{1'b0}}, prep_mag_a};
                        opnd_d = prep_mag_b;
                        neg_d  = op[1] ? prep_neg_a : (prep_neg_a ^ prep_neg_b);
`ifdef MUL_DIV_UNIT_DIV_EN
                        if (in_b == '0) begin
                            special_d = 1'b1;
                            result_d  = op[1] ? in_a : {XLEN{1'b1}};
                        end else if (div_ovf) begin
                            special_d = 1'b1;
                            result_d  = op[1] ? '0 : INT_MIN;
                        end
`else
                        special_d = 1'b1;
                        result_d  = '0;
`endif
                    end else begin
                        acc_d  = {{XLEN{1'b0}}, prep_mag_b};
                        opnd_d = prep_mag_a;
                        neg_d  = prep_neg_a ^ prep_neg_b;
                    end
                end
            end
            S_BUSY: begin
                // Special cases spend exactly one cycle here with the result already loaded.
                if (special_q) begin
                    state_d = S_DONE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
`ifdef MUL_DIV_UNIT_DIV_EN
                    acc_d = is_div(op_q) ? div_step : mul_step;
`else
                    acc_d = mul_step;
`endif
                end else begin
`ifdef MUL_DIV_UNIT_DIV_EN
                    result_d = is_div(op_q) ? div_res : mul_res;
`else
                    result_d = mul_res;
`endif
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= OP_MUL;
            acc_q     <= '0;
            opnd_q    <= '0;
            neg_q     <= 1'b0;
            special_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            neg_q     <= neg_d;
            special_q <= special_d;
            result_q  <= result_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign result    = result_q;
    assign zero      = (result_q == '0);

endmodule

`default_nettype wire

// File: tb/tb_mul_div_unit.sv
// ============================================================================
// tb_mul_div_unit : directed self-checking bench for mul_div_unit (XLEN = 32)
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_mul_div_unit;

`ifdef MUL_DIV_UNIT_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    mul_div_unit #(
        .XLEN (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // With the divider removed, divide ops finish in one cycle with result 0.
    function automatic logic [31:0] dv(input logic [31:0] v);
        return DIV_EN ? v : 32'h0;
    endfunction

    function automatic int dl(input int l);
        return DIV_EN ? l : 1;
    endfunction

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat;
        lat = 0;
        @(negedge clk);
        in_valid = 1'b1;
        op       = o;
        in_a     = a;
        in_b     = b;
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op       = ~o;
        in_a     = $urandom;
        in_b     = $urandom;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " result"}, result, exp);
        check({tag, " zero"}, 32'(zero), 32'(exp == 32'h0));
        if (out_ready) begin
            @(posedge clk);
            #1;
            check({tag, " back to idle"}, 32'(in_ready), 32'd1);
        end
    endtask

    initial begin
        bit seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op        = 3'b000;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset busy", 32'(busy), 32'd0);
        check("reset zero", 32'(zero), 32'd1);
        check("reset result", result, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("MUL 5x6",        3'b000, 32'd5,        32'd6,        32'h0000001E, 33);
        run_op("MUL -1x-1 lo",   3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33);
        run_op("MULH min*min",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33);
        run_op("MULHU max*max",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
        run_op("MULHSU -1*max",  3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
        run_op("MUL 0x7",        3'b000, 32'd0,        32'd7,        32'h00000000, 33);

        run_op("DIV -7/2",       3'b100, 32'hFFFFFFF9, 32'd2, dv(32'hFFFFFFFD), dl(33));
        run_op("REM -7/2",       3'b110, 32'hFFFFFFF9, 32'd2, dv(32'hFFFFFFFF), dl(33));
        run_op("DIVU 100/7",     3'b101, 32'd100,      32'd7, dv(32'd14),       dl(33));
        run_op("REMU 100/7",     3'b111, 32'd100,      32'd7, dv(32'd2),        dl(33));
        run_op("DIVU 7/0",       3'b101, 32'd7,        32'd0, dv(32'hFFFFFFFF), 1);
        run_op("REM 7/0",        3'b110, 32'd7,        32'd0, dv(32'd7),        1);
        run_op("DIV ovf",        3'b100, 32'h80000000, 32'hFFFFFFFF, dv(32'h80000000), 1);
        run_op("REM ovf",        3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0,     1);

        // Backpressure: result must hold and new requests must be ignored while in DONE.
        out_ready = 1'b0;
        run_op("bp MUL 5x6", 3'b000, 32'd5, 32'd6, 32'h0000001E, 33);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = i[0];
            op       = 3'b011;
            in_a     = 32'h12345678;
            in_b     = 32'h9ABCDEF0;
            @(posedge clk);
            #1;
            check("bp result hold", result, 32'h0000001E);
            check("bp in_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp release in_ready", 32'(in_ready), 32'd1);
        check("bp release out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("bp no ghost op", 32'(busy), 32'd0);

        // Reset mid-BUSY abandons the operation; a request during reset is not accepted.
        @(negedge clk);
        in_valid = 1'b1;
        op       = 3'b000;
        in_a     = 32'd3;
        in_b     = 32'd3;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst result", result, 32'h0);
        check("rst in_ready", 32'(in_ready), 32'd1);
        check("rst busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        seen     = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid || busy) seen = 1'b1;
        end
        check("rst no stale result", 32'(seen), 32'd0);

        run_op("post-rst MUL 7x9", 3'b000, 32'd7, 32'd9, 32'd63, 33);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        n_err++;
        $display("FAIL timeout: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
